// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS32 core: branch conditions, redirect kinds
// and the fetch sequencer state.
package mips_pkg;

  typedef enum logic [2:0] {
    COND_NEVER,
    COND_EQ,
    COND_NE,
    COND_GE,
    COND_GT,
    COND_LE,
    COND_LT,
    COND_ALWAYS
  } cond_t;

  typedef enum logic [1:0] {
    REDIR_BR,
    REDIR_J,
    REDIR_JR,
    REDIR_RSVD
  } redir_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_DROP
  } fetch_state_t;

endpackage

// File: rtl/mips_branch_target.sv
// Combinational taken decision and target address for branch, jump and
// jump-register; shared with the pipelined core.
module mips_branch_target
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [1:0]        kind,
  input  logic [2:0]        cond,
  input  logic              zero,
  input  logic              less,
  input  logic [ADDR_W-1:0] pc,
  input  logic [25:0]       imm,
  input  logic [ADDR_W-1:0] rs_val,
  output logic              take,
  output logic [ADDR_W-1:0] target
);

  localparam logic [ADDR_W-1:0] LOW28 = ADDR_W'({28{1'b1}});

  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] j_low;

  always_comb begin
    seq    = pc + ADDR_W'(4);
    br_off = {{(ADDR_W-18){imm[15]}}, imm[15:0], 2'b00};
    j_low  = ADDR_W'({imm, 2'b00});
    take   = 1'b0;
    target = '0;
    case (redir_kind_t'(kind))
      REDIR_BR: begin
        target = seq + br_off;
        case (cond_t'(cond))
          COND_NEVER:  take = 1'b0;
          COND_EQ:     take = zero;
          COND_NE:     take = !zero;
          COND_GE:     take = !less;
          COND_GT:     take = !(less || zero);
          COND_LE:     take = less || zero;
          COND_LT:     take = less;
          COND_ALWAYS: take = 1'b1;
        endcase
      end
      REDIR_J: begin
        take   = 1'b1;
        target = (seq & ~LOW28) | j_low;
      end
      REDIR_JR: begin
        take   = 1'b1;
        target = rs_val & ~ADDR_W'(3);
      end
      default: begin
        take   = 1'b0;
        target = '0;
      end
    endcase
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Handshaked instruction fetch and next-PC sequencer with branch/jump
// redirect handling and optional architectural delay slot.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                DELAY_SLOT = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              ir_valid,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  input  logic              redir_valid,
  input  logic [1:0]        redir_kind,
  input  logic [2:0]        redir_cond,
  input  logic              redir_zero,
  input  logic              redir_less,
  input  logic [ADDR_W-1:0] redir_pc,
  input  logic [25:0]       redir_imm,
  input  logic [ADDR_W-1:0] redir_reg,
  output logic              taken
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
  logic [ADDR_W-1:0] ir_pc_n;
  logic [31:0]       ir_n;
  logic              pend_valid, pend_valid_n;
  logic [ADDR_W-1:0] pend_target, pend_target_n;
  logic              br_take;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] tgt;
  logic              accept;
  logic              squash;

  mips_branch_target #(.ADDR_W(ADDR_W)) u_branch_target (
    .kind   (redir_kind),
    .cond   (redir_cond),
    .zero   (redir_zero),
    .less   (redir_less),
    .pc     (redir_pc),
    .imm    (redir_imm),
    .rs_val (redir_reg),
    .take   (br_take),
    .target (br_target)
  );

  assign tgt       = {br_target[ADDR_W-1:2], 2'b00};
  assign accept    = redir_valid && br_take && (state != ST_IDLE) && !pend_valid;
  assign squash    = accept && (DELAY_SLOT == 0);
  assign imem_addr = fetch_pc;

  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    ir_n          = ir;
    ir_pc_n       = ir_pc;
    pend_valid_n  = pend_valid;
    pend_target_n = pend_target;
    imem_req      = 1'b0;
    ir_valid      = 1'b0;
    case (state)
      ST_IDLE: state_n = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (squash) begin
          if (imem_ready) begin
            fetch_pc_n = tgt;
          end else begin
            state_n       = ST_DROP;
            pend_valid_n  = 1'b1;
            pend_target_n = tgt;
          end
        end else begin
          if (accept) begin
            pend_valid_n  = 1'b1;
            pend_target_n = tgt;
          end
          if (imem_ready) begin
            ir_n    = imem_rdata;
            ir_pc_n = fetch_pc;
            state_n = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (squash) begin
          fetch_pc_n = tgt;
          state_n    = ST_FETCH;
        end else begin
          ir_valid = 1'b1;
          // A slot word leaving in the same cycle its redirect arrives goes
          // straight to the new target instead of parking it as pending.
          if (ir_ready) begin
            state_n      = ST_FETCH;
            pend_valid_n = 1'b0;
            if (accept)          fetch_pc_n = tgt;
            else if (pend_valid) fetch_pc_n = pend_target;
            else                 fetch_pc_n = ir_pc + ADDR_W'(4);
          end else if (accept) begin
            pend_valid_n  = 1'b1;
            pend_target_n = tgt;
          end
        end
      end
      ST_DROP: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          fetch_pc_n   = pend_target;
          pend_valid_n = 1'b0;
          state_n      = ST_FETCH;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      fetch_pc    <= RESET_PC;
      ir          <= '0;
      ir_pc       <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      taken       <= 1'b0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      ir          <= ir_n;
      ir_pc       <= ir_pc_n;
      pend_valid  <= pend_valid_n;
      pend_target <= pend_target_n;
      taken       <= accept;
    end
  end

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Parametrised instruction-fetch and next-PC sequencer for the multi-cycle MIPS32 core. It replaces the single-cycle PC register and next-PC mux with a handshaked unit: it fetches from an instruction memory that may insert wait states, and holds each instruction word until decode accepts it. It also resolves branch, jump and jump-register redirects from execute, with an optional architectural branch delay slot. It sits between the instruction memory port and the decode stage.

## Interface
Parameters:
- ADDR_W, 32: PC / address width; legal range 28..32.
- RESET_PC, 0: fetch address after reset; word aligned.
- DELAY_SLOT, 0: 1 = the instruction after a taken branch/jump executes; 0 = it is squashed.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held with stable imem_addr until imem_ready.
- imem_addr  out  ADDR_W  fetch address; bits [1:0] always 0.
- imem_ready  in  1  fetch completes in the cycle where imem_req && imem_ready; may be high in the request's first cycle (zero wait).
- imem_rdata  in  32  instruction word, valid when imem_req && imem_ready.
- ir_valid  out  1  held instruction available to decode.
- ir  out  32  held instruction word.
- ir_pc  out  ADDR_W  address of ir.
- ir_ready  in  1  decode accepts; transfer when ir_valid && ir_ready.
- redir_valid  in  1  execute presents a control-flow instruction this cycle.
- redir_kind  in  2  0 branch, 1 jump (J/JAL), 2 jump-register, 3 reserved (no effect).
- redir_cond  in  3  branch condition: 0 never, 1 ==, 2 !=, 3 >=, 4 >, 5 <=, 6 <, 7 always.
- redir_zero, redir_less  in  1 each  ALU flags for the branch compare.
- redir_pc  in  ADDR_W  address of the control-flow instruction.
- redir_imm  in  26  IR[25:0] of that instruction.
- redir_reg  in  ADDR_W  R[Rs], used for jump-register.
- taken  out  1  registered one-cycle pulse: a redirect was taken on the previous edge.

## Operation
- Taken: kind 1/2 always; kind 0 per redir_cond (3 = !less, 4 = !(less||zero), 5 = less||zero, 6 = less); kind 3 never.
- Targets, all arithmetic modulo 2^ADDR_W, with seq = redir_pc+4:
  - branch: seq + (sign-extended redir_imm[15:0] << 2);
  - jump: {seq[ADDR_W-1:28], redir_imm, 2'b00};
  - jump-register: redir_reg with bits [1:0] cleared.
- FSM states:
  - IDLE: reset state; unconditionally goes to FETCH on the next edge.
  - FETCH: imem_req=1; on ready captures the word and goes to HOLD.
  - HOLD: ir_valid=1; on an accepted transfer goes to FETCH at ir_pc+4 or at the pending target.
  - DROP: imem_req=1; waits for the squashed in-flight word, discards it, then goes to FETCH at the target.
- DELAY_SLOT=0, taken redirect:
  - in HOLD: the held word is squashed; ir_valid is combinationally forced 0 that cycle, and no transfer occurs even if ir_ready=1; next state FETCH at the target.
  - in FETCH: ready that same cycle drops the word and goes to FETCH at the target; otherwise goes to DROP.
- DELAY_SLOT=1, taken redirect: the held or in-flight sequential word is the slot and is delivered normally. The target is stored in a pending register and used instead of +4 for the next fetch.
- A second taken redirect while a target is pending is ignored.
- Redirects in IDLE are ignored. Not-taken redirects have no effect.
- Priority: reset > taken redirect > sequential advance.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, ir_valid=0, ir=0, ir_pc=RESET_PC, taken=0, no pending target, state IDLE.
- After reset release, imem_req rises after the first edge, with imem_addr=RESET_PC.
- Latency is imem_ready to ir_valid in 1 cycle. Peak throughput is 1 instruction per 2 cycles with zero-wait memory and ir_ready held high.
- taken pulses high for exactly one cycle after the edge that samples the taken redirect.
- Reset asserted mid-fetch drops imem_req immediately (asynchronous); an in-flight word is never delivered.
- With DELAY_SLOT=0, a redirect to the currently held ir_pc still squashes and refetches it.

## Structure
- Shared package mips_pkg holds:
  - condition codes COND_NEVER..COND_ALWAYS;
  - redirect kinds REDIR_BR/J/JR;
  - the fetch state enum.
- Combinational sub-module mips_branch_target computes taken and the target address; it is reused by the later pipelined core.

## Test plan
- Reset with RESET_PC=0x100, zero-wait memory, ir_ready=1 -> ir_pc sequence 0x100, 0x104, 0x108; ir_valid high every second cycle.
- imem_ready delayed 3 cycles -> imem_addr stable for 4 cycles; ir_valid rises 1 cycle after ready.
- DELAY_SLOT=0: BEQ at 0x20 with zero=1, imm=0xFFFF, in the cycle 0x24 is held -> 0x24 never transferred; next ir_pc 0x20; taken pulses once.
- DELAY_SLOT=1: same stimulus -> 0x24 transferred, then ir_pc 0x20.
- JR with redir_reg=0x403 while the fetch of 0x34 is outstanding (DELAY_SLOT=0) -> DROP state; word discarded; next imem_addr=0x400.
- Branch with cond=4, less=0, zero=1 -> not taken; taken stays 0; sequential flow continues.
